// File: rtl/sr_lsu_if.sv
// Memory-side request/response bus between sr_lsu (master) and the RAM controller (slave).
interface sr_lsu_if #(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned ADDR_W = 32
);
  localparam int unsigned NB = DATA_W / 8;

  logic              memReq;
  logic              memWe;
  logic [ADDR_W-1:0] memAddress;
  logic [NB-1:0]     memByteEn;
  logic [DATA_W-1:0] memData;
  logic              memReady;
  logic              memRespValid;
  logic [DATA_W-1:0] memRespData;

  modport master (
    output memReq, memWe, memAddress, memByteEn, memData,
    input  memReady, memRespValid, memRespData
  );

  modport slave (
    input  memReq, memWe, memAddress, memByteEn, memData,
    output memReady, memRespValid, memRespData
  );
endinterface

// File: rtl/sr_lsu.sv
// Load/store unit: effective address, registered req/ready/resp handshake, byte-lane steering and load extension.
// Optional WAIT-state bus timeout is enabled by defining SR_LSU_TIMEOUT_EN.
module sr_lsu #(
  parameter int unsigned DATA_W    = 32,
  parameter int unsigned ADDR_W    = 32,
  parameter int unsigned TIMEOUT_W = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [1:0]        lsuOp,
  input  logic [1:0]        lsuSize,
  input  logic              lsuUnsigned,
  input  logic [ADDR_W-1:0] baseAddr,
  input  logic [ADDR_W-1:0] offset,
  input  logic [DATA_W-1:0] storeData,
  output logic              cpuPause_n,
  output logic [DATA_W-1:0] loadData,
  output logic              lsuFault,
  sr_lsu_if.master          mem
);

  localparam int unsigned NB      = DATA_W / 8;
  localparam int unsigned LANE_W  = $clog2(NB);
  localparam int unsigned SHIFT_W = LANE_W + 3;

  typedef enum logic [2:0] {IDLE, REQ, WAIT, DONE, FAULT} state_t;

  state_t state;
  state_t stateNext;

  logic              opLoad;
  logic              opStore;
  logic              opActive;
  logic [ADDR_W-1:0] ea;
  logic [LANE_W-1:0] lane;
  logic              misaligned;
  logic [NB-1:0]     byteEnC;
  logic [DATA_W-1:0] dataC;

  logic              reqLoad;
  logic [1:0]        reqSize;
  logic              reqUnsigned;
  logic [LANE_W-1:0] reqLane;
  logic [DATA_W-1:0] respShift;
  logic [DATA_W-1:0] respExt;

  logic              launch;
  logic              capture;
  logic              timeoutHit;

  assign opLoad   = (lsuOp == 2'b01);
  assign opStore  = (lsuOp == 2'b10);
  assign opActive = opLoad | opStore;
  assign ea       = baseAddr + offset;
  assign lane     = ea[LANE_W-1:0];

  assign cpuPause_n = rst | ~opActive | (state == DONE) | (state == FAULT);

  // Alignment check and lane steering of the outgoing request
  always_comb begin
    misaligned = 1'b0;
    byteEnC    = '1;
    dataC      = storeData;
    case (lsuSize)
      2'b00: begin
        byteEnC = NB'(1) << lane;
        dataC   = {NB{storeData[7:0]}};
      end
      2'b01: begin
        misaligned = lane[0];
        byteEnC    = NB'(3) << lane;
        dataC      = {(NB/2){storeData[15:0]}};
      end
      default: misaligned = (lane != '0);
    endcase
  end

  // Pull the addressed byte/half down to bit 0 and extend it
  assign respShift = mem.memRespData >> SHIFT_W'({reqLane, 3'b000});

  always_comb begin
    respExt = respShift;
    case (reqSize)
      2'b00: respExt = reqUnsigned ? DATA_W'(respShift[7:0])  : DATA_W'($signed(respShift[7:0]));
      2'b01: respExt = reqUnsigned ? DATA_W'(respShift[15:0]) : DATA_W'($signed(respShift[15:0]));
      default: ;
    endcase
  end

`ifdef SR_LSU_TIMEOUT_EN
  logic [TIMEOUT_W-1:0] tmoCnt;

  // Counts WAIT cycles; cleared while in REQ so it starts at zero on WAIT entry
  always_ff @(posedge clk or posedge rst) begin
    if (rst)                tmoCnt <= '0;
    else if (state == REQ)  tmoCnt <= '0;
    else if (state == WAIT) tmoCnt <= tmoCnt + TIMEOUT_W'(1);
  end

  // Last permitted WAIT cycle is the (2**TIMEOUT_W-1)-th one
  assign timeoutHit = (tmoCnt == {{(TIMEOUT_W-1){1'b1}}, 1'b0});
`else
  logic unusedTimeoutW;
  assign unusedTimeoutW = (TIMEOUT_W != 0);
  assign timeoutHit     = 1'b0;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= stateNext;
  end

  always_comb begin
    stateNext = state;
    launch    = 1'b0;
    capture   = 1'b0;
    case (state)
      IDLE: begin
        if (opActive) begin
          stateNext = misaligned ? FAULT : REQ;
          launch    = ~misaligned;
        end
      end
      REQ: begin
        if (mem.memReady) begin
          if (!reqLoad) begin
            stateNext = DONE;
          end else if (mem.memRespValid) begin
            stateNext = DONE;
            capture   = 1'b1;
          end else begin
            stateNext = WAIT;
          end
        end
      end
      WAIT: begin
        if (mem.memRespValid) begin
          stateNext = DONE;
          capture   = 1'b1;
        end else if (timeoutHit) begin
          stateNext = FAULT;
        end
      end
      DONE:    stateNext = IDLE;
      FAULT:   stateNext = IDLE;
      default: stateNext = IDLE;
    endcase
  end

  // Registered bus outputs, request context and load result
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mem.memReq     <= 1'b0;
      mem.memWe      <= 1'b0;
      mem.memAddress <= '0;
      mem.memByteEn  <= '0;
      mem.memData    <= '0;
      lsuFault       <= 1'b0;
      loadData       <= '0;
      reqLoad        <= 1'b0;
      reqSize        <= 2'b00;
      reqUnsigned    <= 1'b0;
      reqLane        <= '0;
    end else begin
      mem.memReq <= (stateNext == REQ);
      lsuFault   <= (stateNext == FAULT);
      if (launch) begin
        mem.memWe      <= opStore;
        mem.memAddress <= {ea[ADDR_W-1:LANE_W], {LANE_W{1'b0}}};
        mem.memByteEn  <= byteEnC;
        mem.memData    <= dataC;
        reqLoad        <= opLoad;
        reqSize        <= lsuSize;
        reqUnsigned    <= lsuUnsigned;
        reqLane        <= lane;
      end
      if (capture)                 loadData <= respExt;
      else if (stateNext == FAULT) loadData <= '0;
    end
  end

endmodule

// File: tb/tb_sr_lsu.sv
// Self-checking bench for sr_lsu: directed vector table, random ops against a byte-level model, reset/timeout sequences.
module tb_sr_lsu;

  localparam int unsigned DATA_W    = 32;
  localparam int unsigned ADDR_W    = 32;
  localparam int unsigned TIMEOUT_W = 3;

  logic        clk = 1'b0;
  logic        rst;
  logic [1:0]  lsuOp;
  logic [1:0]  lsuSize;
  logic        lsuUnsigned;
  logic [31:0] baseAddr;
  logic [31:0] offset;
  logic [31:0] storeData;
  logic        cpuPause_n;
  logic [31:0] loadData;
  logic        lsuFault;

  int errors = 0;
  int checks = 0;

  sr_lsu_if #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) memIf ();

  sr_lsu #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .TIMEOUT_W(TIMEOUT_W)) dut (
    .clk        (clk),
    .rst        (rst),
    .lsuOp      (lsuOp),
    .lsuSize    (lsuSize),
    .lsuUnsigned(lsuUnsigned),
    .baseAddr   (baseAddr),
    .offset     (offset),
    .storeData  (storeData),
    .cpuPause_n (cpuPause_n),
    .loadData   (loadData),
    .lsuFault   (lsuFault),
    .mem        (memIf.master)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [1:0]  op;
    logic [1:0]  size;
    logic        uns;
    logic [31:0] base;
    logic [31:0] off;
    logic [31:0] sd;
    logic [31:0] resp;
    int          rd;    // cycles of memReq before memReady
    int          rdly;  // cycles after acceptance until memRespValid; <0 = never
  } vec_t;

  typedef struct {
    logic        fault;
    logic [31:0] addr;
    logic [3:0]  be;
    logic [31:0] data;
    logic [31:0] load;
  } exp_t;

  typedef struct {
    vec_t v;
    exp_t e;
  } rec_t;

  typedef struct {
    int          doneCyc;
    int          reqN;
    int          faultN;
    logic [31:0] addr;
    logic [3:0]  be;
    logic [31:0] data;
    logic        we;
    logic [31:0] load;
    logic        pauseAfter;
    logic        faultAfter;
    logic        reqAfter;
  } obs_t;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=0x%0h required=0x%0h", name, act, req);
    end
  endtask

  // Reference: byte-granular view of the access
  function automatic exp_t model(input vec_t v);
    exp_t        e;
    logic [31:0] ea;
    int          n;
    int          ln;
    ea      = v.base + v.off;
    n       = (v.size == 2'b00) ? 1 : (v.size == 2'b01) ? 2 : 4;
    ln      = int'(ea % 32'd4);
    e.fault = (ea % 32'(n)) != 0;
    e.addr  = ea - 32'(ln);
    e.be    = 4'(((1 << n) - 1) << ln);
    e.data  = '0;
    e.load  = '0;
    for (int i = 0; i < 4; i++) e.data[i*8 +: 8] = v.sd[(i % n)*8 +: 8];
    if (v.op == 2'b01 && !e.fault) begin
      for (int i = 0; i < n; i++) e.load[i*8 +: 8] = v.resp[(ln + i)*8 +: 8];
      if (!v.uns && e.load[n*8-1])
        for (int i = n; i < 4; i++) e.load[i*8 +: 8] = 8'hFF;
    end
    return e;
  endfunction

  // Drives one op as the core plus a controller with the vector's delays; called just after a negedge
  task automatic runOp(input vec_t v, output obs_t o);
    bit fin;
    bit accepted;
    bit readySet;
    int sinceAcc;
    bit isLoad;
    isLoad      = (v.op == 2'b01);
    lsuOp       = v.op;
    lsuSize     = v.size;
    lsuUnsigned = v.uns;
    baseAddr    = v.base;
    offset      = v.off;
    storeData   = v.sd;
    o           = '{default: '0};
    o.doneCyc   = -1;
    fin = 0; accepted = 0; readySet = 0; sinceAcc = 0;
    for (int cyc = 1; cyc <= 400 && !fin; cyc++) begin
      @(negedge clk);
      memIf.memReady     = 1'b0;
      memIf.memRespValid = 1'b0;
      memIf.memRespData  = '0;
      if (accepted) sinceAcc++;
      if (readySet) begin accepted = 1; readySet = 0; sinceAcc = 1; end
      if (memIf.memReq) begin
        if (o.reqN == 0) begin
          o.addr = memIf.memAddress; o.be = memIf.memByteEn;
          o.data = memIf.memData;    o.we = memIf.memWe;
        end
        o.reqN++;
      end
      if (lsuFault) o.faultN++;
      if (cpuPause_n) begin
        o.doneCyc = cyc;
        o.load    = loadData;
        fin       = 1;
      end else begin
        if (memIf.memReq && !accepted && o.reqN > v.rd) begin
          memIf.memReady = 1'b1;
          readySet       = 1;
          if (isLoad && v.rdly == 0) begin
            memIf.memRespValid = 1'b1; memIf.memRespData = v.resp;
          end
        end
        if (accepted && isLoad && v.rdly > 0 && sinceAcc == v.rdly) begin
          memIf.memRespValid = 1'b1; memIf.memRespData = v.resp;
        end
      end
    end
    @(negedge clk);
    memIf.memReady     = 1'b0;
    memIf.memRespValid = 1'b0;
    o.pauseAfter = cpuPause_n;
    o.faultAfter = lsuFault;
    o.reqAfter   = memIf.memReq;
    lsuOp        = 2'b00;
  endtask

  task automatic checkOp(input string tag, input vec_t v, input exp_t e);
    obs_t o;
    bit   isLoad;
    bit   tmo;
    int   expDone;
    runOp(v, o);
    isLoad  = (v.op == 2'b01);
    tmo     = isLoad && v.rdly < 0 && !e.fault;
    expDone = e.fault ? 1 : tmo ? 2 + v.rd + int'((2 ** TIMEOUT_W) - 1) : 2 + v.rd + (isLoad ? v.rdly : 0);
    check($sformatf("%s doneCyc", tag), o.doneCyc, expDone);
    check($sformatf("%s faultPulses", tag), o.faultN, (e.fault || tmo) ? 1 : 0);
    check($sformatf("%s reqCycles", tag), o.reqN, e.fault ? 0 : v.rd + 1);
    if (!e.fault) begin
      check($sformatf("%s memAddress", tag), o.addr, e.addr);
      check($sformatf("%s memByteEn", tag), 32'(o.be), 32'(e.be));
      check($sformatf("%s memWe", tag), 32'(o.we), 32'(!isLoad));
      if (!isLoad) check($sformatf("%s memData", tag), o.data, e.data);
    end
    if (isLoad || e.fault) check($sformatf("%s loadData", tag), o.load, tmo ? 32'h0 : e.load);
    check($sformatf("%s pauseAfter", tag), 32'(o.pauseAfter), 32'h0);
    check($sformatf("%s faultAfter", tag), 32'(o.faultAfter), 32'h0);
    check($sformatf("%s reqAfter", tag), 32'(o.reqAfter), 32'h0);
  endtask

  function automatic vec_t mkVec(input logic [1:0] op, input logic [1:0] size, input logic uns,
                                 input logic [31:0] base, input logic [31:0] off, input logic [31:0] sd,
                                 input logic [31:0] resp, input int rd, input int rdly);
    vec_t v;
    v.op = op; v.size = size; v.uns = uns; v.base = base; v.off = off;
    v.sd = sd; v.resp = resp; v.rd = rd; v.rdly = rdly;
    return v;
  endfunction

  function automatic exp_t mkExp(input logic fault, input logic [31:0] addr, input logic [3:0] be,
                                 input logic [31:0] data, input logic [31:0] load);
    exp_t e;
    e.fault = fault; e.addr = addr; e.be = be; e.data = data; e.load = load;
    return e;
  endfunction

  initial begin
    rec_t        tbl[10];
    vec_t        v;
    logic [31:0] held;

    rst = 1'b1; lsuOp = 2'b01; lsuSize = 2'b10; lsuUnsigned = 1'b0;
    baseAddr = 32'h100; offset = '0; storeData = '0;
    memIf.memReady = 1'b0; memIf.memRespValid = 1'b0; memIf.memRespData = '0;

    // Reset state, with an active op held so cpuPause_n must come from rst
    repeat (2) @(negedge clk);
    check("rst memReq", 32'(memIf.memReq), 32'h0);
    check("rst memWe", 32'(memIf.memWe), 32'h0);
    check("rst lsuFault", 32'(lsuFault), 32'h0);
    check("rst memAddress", memIf.memAddress, 32'h0);
    check("rst memByteEn", 32'(memIf.memByteEn), 32'h0);
    check("rst memData", memIf.memData, 32'h0);
    check("rst loadData", loadData, 32'h0);
    check("rst cpuPause_n", 32'(cpuPause_n), 32'h1);
    lsuOp = 2'b00;
    rst   = 1'b0;
    @(negedge clk);

    // Directed table: inputs plus hand-derived expectations
    tbl[0] = '{mkVec(2'b01, 2'b10, 1'b0, 32'h100, 32'h4, 32'h0, 32'hDEADBEEF, 2, 3),
               mkExp(1'b0, 32'h104, 4'b1111, 32'h0, 32'hDEADBEEF)};
    tbl[1] = '{mkVec(2'b01, 2'b00, 1'b0, 32'h100, 32'h3, 32'h0, 32'h80FF0000, 0, 1),
               mkExp(1'b0, 32'h100, 4'b1000, 32'h0, 32'hFFFFFF80)};
    tbl[2] = '{mkVec(2'b01, 2'b00, 1'b1, 32'h100, 32'h3, 32'h0, 32'h80FF0000, 1, 2),
               mkExp(1'b0, 32'h100, 4'b1000, 32'h0, 32'h00000080)};
    tbl[3] = '{mkVec(2'b10, 2'b01, 1'b0, 32'h100, 32'h2, 32'h1234ABCD, 32'h0, 1, 0),
               mkExp(1'b0, 32'h100, 4'b1100, 32'hABCDABCD, 32'h0)};
    tbl[4] = '{mkVec(2'b01, 2'b10, 1'b0, 32'h100, 32'h1, 32'h0, 32'h11111111, 0, 0),
               mkExp(1'b1, 32'h0, 4'b0000, 32'h0, 32'h0)};
    tbl[5] = '{mkVec(2'b01, 2'b01, 1'b0, 32'h100, 32'h2, 32'h0, 32'h80017FFF, 0, 0),
               mkExp(1'b0, 32'h100, 4'b1100, 32'h0, 32'hFFFF8001)};
    tbl[6] = '{mkVec(2'b10, 2'b00, 1'b0, 32'h10, 32'hFFFFFFF7, 32'hAAAABB55, 32'h0, 0, 0),
               mkExp(1'b0, 32'h4, 4'b1000, 32'h55555555, 32'h0)};
    tbl[7] = '{mkVec(2'b01, 2'b01, 1'b1, 32'h100, 32'h5, 32'h0, 32'h0, 0, 0),
               mkExp(1'b1, 32'h0, 4'b0000, 32'h0, 32'h0)};
    tbl[8] = '{mkVec(2'b10, 2'b11, 1'b0, 32'h1F0, 32'h10, 32'hCAFEF00D, 32'h0, 3, 0),
               mkExp(1'b0, 32'h200, 4'b1111, 32'hCAFEF00D, 32'h0)};
    tbl[9] = '{mkVec(2'b01, 2'b01, 1'b1, 32'hFFFFFFFC, 32'h8, 32'h0, 32'h0000F00F, 2, 1),
               mkExp(1'b0, 32'h4, 4'b0011, 32'h0, 32'h0000F00F)};
    for (int i = 0; i < 10; i++) checkOp($sformatf("dir%0d", i), tbl[i].v, tbl[i].e);

    // Idle encodings: no request, no fault, ready/resp ignored, loadData held
    held = loadData;
    for (int k = 0; k < 6; k++) begin
      lsuOp              = (k < 3) ? 2'b00 : 2'b11;
      memIf.memReady     = 1'b1;
      memIf.memRespValid = 1'b1;
      memIf.memRespData  = $urandom;
      @(negedge clk);
      check($sformatf("idle%0d memReq", k), 32'(memIf.memReq), 32'h0);
      check($sformatf("idle%0d lsuFault", k), 32'(lsuFault), 32'h0);
      check($sformatf("idle%0d cpuPause_n", k), 32'(cpuPause_n), 32'h1);
      check($sformatf("idle%0d loadData", k), loadData, held);
    end
    lsuOp = 2'b00; memIf.memReady = 1'b0; memIf.memRespValid = 1'b0;
    @(negedge clk);

    // Random ops against the model
    for (int i = 0; i < 60; i++) begin
      v.op   = ($urandom_range(0, 1) != 0) ? 2'b01 : 2'b10;
      v.size = 2'($urandom_range(0, 3));
      v.uns  = 1'($urandom_range(0, 1));
      v.base = $urandom;
      v.off  = 32'($urandom_range(0, 63)) - 32'd32;
      v.sd   = $urandom;
      v.resp = $urandom;
      v.rd   = int'($urandom_range(0, 3));
      v.rdly = int'($urandom_range(0, 3));
      checkOp($sformatf("rnd%0d", i), v, model(v));
    end

`ifdef SR_LSU_TIMEOUT_EN
    // No response: FAULT after 2**TIMEOUT_W-1 WAIT cycles, loadData forced to 0
    v = mkVec(2'b01, 2'b10, 1'b0, 32'h300, 32'h0, 32'h0, 32'h12345678, 1, -1);
    checkOp("timeout", v, model(v));
`else
    // No response: WAIT persists indefinitely, then a late response completes normally
    lsuOp = 2'b01; lsuSize = 2'b10; lsuUnsigned = 1'b0; baseAddr = 32'h300; offset = 32'h0;
    @(negedge clk);
    check("noTmo reqVisible", 32'(memIf.memReq), 32'h1);
    memIf.memReady = 1'b1;
    @(negedge clk);
    memIf.memReady = 1'b0;
    repeat (98) @(negedge clk);
    check("noTmo memReq", 32'(memIf.memReq), 32'h0);
    check("noTmo cpuPause_n", 32'(cpuPause_n), 32'h0);
    check("noTmo lsuFault", 32'(lsuFault), 32'h0);
    memIf.memRespValid = 1'b1; memIf.memRespData = 32'h13579BDF;
    @(negedge clk);
    memIf.memRespValid = 1'b0;
    check("noTmo donePause", 32'(cpuPause_n), 32'h1);
    check("noTmo loadData", loadData, 32'h13579BDF);
    @(negedge clk);
    lsuOp = 2'b00;
    @(negedge clk);
`endif

    // Reset while memReq is high drops it without waiting for a clock edge
    lsuOp = 2'b01; lsuSize = 2'b10; baseAddr = 32'h400; offset = 32'h0;
    @(negedge clk);
    check("rstReq memReqBefore", 32'(memIf.memReq), 32'h1);
    #2 rst = 1'b1;
    #1;
    check("rstReq memReqAsync", 32'(memIf.memReq), 32'h0);
    check("rstReq cpuPause_n", 32'(cpuPause_n), 32'h1);
    check("rstReq loadData", loadData, 32'h0);
    lsuOp = 2'b00;
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);

    // Reset in WAIT, then a stale response must be ignored
    lsuOp = 2'b01; baseAddr = 32'h404;
    @(negedge clk);
    memIf.memReady = 1'b1;
    @(negedge clk);
    memIf.memReady = 1'b0;
    check("rstWait inWait", 32'(cpuPause_n), 32'h0);
    rst = 1'b1;
    #1;
    check("rstWait memReq", 32'(memIf.memReq), 32'h0);
    lsuOp = 2'b00;
    @(negedge clk);
    rst = 1'b0;
    memIf.memRespValid = 1'b1; memIf.memRespData = 32'hFFFFFFFF;
    @(negedge clk);
    memIf.memRespValid = 1'b0;
    check("rstWait loadData", loadData, 32'h0);
    check("rstWait memReq2", 32'(memIf.memReq), 32'h0);
    @(negedge clk);
    check("rstWait loadDataLater", loadData, 32'h0);

    // Unit is usable again after the aborted transfer
    v = mkVec(2'b01, 2'b00, 1'b0, 32'h404, 32'h1, 32'h0, 32'h00007F00, 0, 2);
    checkOp("postRst", v, model(v));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
